fft_64_reorder: RTL and testbench
=================================

FFT_64_REORDER -- requirements
Module: fft_64_reorder

Interface
REQ-001 Parameter WIDTH, default 32, width of each real/imag sample word.
REQ-002 Parameter N, default 64, frame length in samples; fixed to 64 (address width 6).
REQ-003 clock  input  1  single rising-edge clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 input_en  input  1  qualifies input_real/input_imag; one sample accepted per cycle it is high.
REQ-006 input_real  input  WIDTH  real part of incoming sample, bit-reversed frame order (FFT stage-6 output).
REQ-007 input_imag  input  WIDTH  imaginary part of incoming sample.
REQ-008 output_en  output  1  high for each valid natural-order output sample.
REQ-009 output_real  output  WIDTH  real part of output sample, registered.
REQ-010 output_imag  output  WIDTH  imaginary part of output sample, registered.

Function
REQ-011 Storage SHALL be two banks (A, B) of 64 x 2*WIDTH words, ping-pong; the write bank starts as A.
REQ-012 A 6-bit write counter SHALL advance only on input_en; sample k of a frame is written to write-bank address bitrev6(k).
REQ-013 Input gaps (input_en low) SHALL be allowed anywhere in a frame; no sample is lost or duplicated.
REQ-014 On acceptance of sample 63, the counter SHALL wrap to 0, the bank SHALL be marked full, and writing SHALL switch to the other bank in the next cycle.
REQ-015 Read FSM states: IDLE, READ; IDLE->READ when any bank is full; READ->IDLE after address 63 unless the other bank is full, in which case READ SHALL continue with that bank at address 0 without a gap.
REQ-016 In READ, the read address SHALL increment 0..63 once per cycle; each output is a single contiguous 64-cycle burst with output_en high throughout.
REQ-017 Latency: if sample 63 is accepted at edge t and the reader is idle, output address 0 SHALL be valid (output_en=1) after edge t+1, and address 63 after edge t+64.
REQ-018 A bank's full flag SHALL clear after its address 63 is read; a write to that bank is permitted from the following cycle.
REQ-019 Continuous input (input_en permanently high) SHALL produce continuous output after the initial 65-cycle latency; overflow is impossible at one sample per cycle and no stall signal exists.
REQ-020 When output_en is low, output_real/output_imag SHALL hold their last value.
REQ-021 Data SHALL pass through unmodified; no arithmetic is performed on samples.

Reset
REQ-022 reset SHALL clear the write counter, the read address, both full flags, set write bank to A, FSM to IDLE, output_en=0, output_real=0, output_imag=0.
REQ-023 Reset mid-frame or mid-burst SHALL discard partial input and abort the burst; output_en SHALL be 0 in the cycle following the reset edge.
REQ-024 Memory array contents SHALL NOT be reset.

Configuration
REQ-025 Macro FFT_REORDER_BITREV_EN: defined -> write address is bitrev6(k) (natural-order output); undefined -> write address is k, making the block a 64-sample frame buffer with identical timing and handshake.

Verification
REQ-026 Single frame, input_real=k, input_imag=63-k, k=0..63 back-to-back -> 64 outputs with output_real = bitrev6(j): 0,32,16,48,8,...,63, output_imag = 63-bitrev6(j), first at t+1.
REQ-027 Same frame with input_en low on every other cycle -> identical output sequence; output burst still 64 contiguous cycles starting one cycle after sample 63.
REQ-028 Three frames streamed continuously (192 cycles of input_en=1) -> 192 consecutive output_en=1 cycles, frames in order, no gap between bursts.
REQ-029 Reset asserted after 20 samples of a frame, then a full frame -> no output from the partial frame; the full frame emerges correctly starting from address 0.
REQ-030 Reset asserted at burst output 10 -> output_en=0 next cycle, outputs 0; subsequent frame outputs correctly.
REQ-031 Build without FFT_REORDER_BITREV_EN, input_real=k -> output_real=j, j=0..63, same latency.

Source files
------------

// File: rtl/fft_64_reorder.sv
// Ping-pong reorder buffer that turns a bit-reversed 64-sample FFT frame into natural order.
// Build option: define FFT_REORDER_BITREV_EN for bit-reversed write addressing; leave it undefined for a plain frame buffer.
module fft_64_reorder #(
   parameter int WIDTH = 32,
   parameter int N     = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             input_en,
   input  logic [WIDTH-1:0] input_real,
   input  logic [WIDTH-1:0] input_imag,
   output logic             output_en,
   output logic [WIDTH-1:0] output_real,
   output logic [WIDTH-1:0] output_imag
);

   // state | meaning
   // IDLE  | no burst in progress; starts one (emitting address 0) as soon as a bank is full
   // READ  | streaming rd_addr_q of rd_bank_q, one word per cycle

   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic {IDLE, READ} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    wr_cnt_q;
   logic             wr_bank_q;
   logic [1:0]       full_q;
   logic [1:0]       set_full;
   logic [1:0]       clr_full;
   logic [AW-1:0]    wr_addr;
   logic             rd_bank_q, rd_bank_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic             rd_fire;
   logic             rd_sel_bank;
   logic [AW-1:0]    rd_sel_addr;
   logic             pick_bank;
   logic [2*WIDTH-1:0] mem [2][N];
   logic [2*WIDTH-1:0] rd_word;

`ifdef FFT_REORDER_BITREV_EN
   always_comb begin
      wr_addr = '0;
      for (int i = 0; i < AW; i++) begin
         wr_addr[i] = wr_cnt_q[AW-1-i];
      end
   end
`else
   always_comb begin
      wr_addr = wr_cnt_q;
   end
`endif

   always_comb begin
      set_full = '0;
      if (input_en && (wr_cnt_q == LAST)) begin
         set_full[wr_bank_q] = 1'b1;
      end
   end

   // Memory is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (input_en) begin
         mem[wr_bank_q][wr_addr] <= {input_real, input_imag};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
         full_q    <= '0;
      end else begin
         full_q <= (full_q & ~clr_full) | set_full;
         if (input_en) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST) begin
               wr_bank_q <= ~wr_bank_q;
            end
         end
      end
   end

   // If both banks are full, the one the writer is about to reuse holds the older frame.
   assign pick_bank = full_q[wr_bank_q] ? wr_bank_q : ~wr_bank_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rd_bank_q <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_bank_q <= rd_bank_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      rd_addr_d   = rd_addr_q;
      rd_fire     = 1'b0;
      rd_sel_bank = rd_bank_q;
      rd_sel_addr = rd_addr_q;
      clr_full    = '0;
      case (state_q)
         IDLE: begin
            if (full_q != 2'b00) begin
               rd_fire     = 1'b1;
               rd_sel_bank = pick_bank;
               rd_sel_addr = '0;
               rd_bank_d   = pick_bank;
               rd_addr_d   = AW'(1);
               state_d     = READ;
            end
         end
         READ: begin
            rd_fire   = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == LAST) begin
               clr_full[rd_bank_q] = 1'b1;
               if (full_q[~rd_bank_q]) begin
                  rd_bank_d = ~rd_bank_q;
                  rd_addr_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_word = mem[rd_sel_bank][rd_sel_addr];

   always_ff @(posedge clock) begin
      if (reset) begin
         output_en   <= 1'b0;
         output_real <= '0;
         output_imag <= '0;
      end else begin
         output_en <= rd_fire;
         if (rd_fire) begin
            output_real <= rd_word[2*WIDTH-1:WIDTH];
            output_imag <= rd_word[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_fft_64_reorder.sv
// Bench for fft_64_reorder: scenario table plus reset corner sequences, with a scoreboard on the output stream.
// Expectations follow FFT_REORDER_BITREV_EN the same way the design does.
module tb_fft_64_reorder;
   localparam int WIDTH = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic             input_en;
   logic [WIDTH-1:0] input_real;
   logic [WIDTH-1:0] input_imag;
   logic             output_en;
   logic [WIDTH-1:0] output_real;
   logic [WIDTH-1:0] output_imag;

   fft_64_reorder #(.WIDTH(WIDTH), .N(64)) dut (
      .clock       (clock),
      .reset       (reset),
      .input_en    (input_en),
      .input_real  (input_real),
      .input_imag  (input_imag),
      .output_en   (output_en),
      .output_real (output_real),
      .output_imag (output_imag)
   );

   always #5 clock = ~clock;

   typedef struct {
      int gap;
      int frames;
      int base;
      int exp_count;
      int exp_run;
   } scen_t;

   scen_t scen [4];

   logic [2*WIDTH-1:0] exp_q [$];
   int runs [$];
   int checks = 0;
   int errors = 0;
   int out_count = 0;
   int cur_run = 0;

   function automatic int bitrev6(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 6; i++) if (v[i]) r[5-i] = 1'b1;
      return r;
   endfunction

   function automatic int src_index(input int j);
`ifdef FFT_REORDER_BITREV_EN
      return bitrev6(j);
`else
      return j;
`endif
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic monitor();
      logic [2*WIDTH-1:0] e;
      forever begin
         @(negedge clock);
         if (output_en) begin
            out_count++;
            cur_run++;
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_real", output_real, e[2*WIDTH-1:WIDTH]);
               check("out_imag", output_imag, e[WIDTH-1:0]);
            end
         end else if (cur_run != 0) begin
            runs.push_back(cur_run);
            cur_run = 0;
         end
      end
   endtask

   task automatic push_expected(input int base);
      int k;
      for (int j = 0; j < 64; j++) begin
         k = src_index(j);
         exp_q.push_back({WIDTH'(base + k), WIDTH'(base + 63 - k)});
      end
   endtask

   task automatic send_samples(input int base, input int count, input int gap);
      for (int k = 0; k < count; k++) begin
         if (gap != 0) begin
            input_en = 1'b0;
            tick();
         end
         input_en   = 1'b1;
         input_real = WIDTH'(base + k);
         input_imag = WIDTH'(base + 63 - k);
         if (k == 63) push_expected(base);
         tick();
      end
      input_en = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || output_en || cur_run != 0) && budget < 400) begin
         tick();
         budget++;
      end
      tick();
      check("drain_timeout", budget >= 400, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      int c0, r0, mx, budget;
      scen[0] = '{gap: 0, frames: 1, base: 0,    exp_count: 64,  exp_run: 64};
      scen[1] = '{gap: 1, frames: 1, base: 1000, exp_count: 64,  exp_run: 64};
      scen[2] = '{gap: 0, frames: 3, base: 2000, exp_count: 192, exp_run: 192};
      scen[3] = '{gap: 1, frames: 2, base: 5000, exp_count: 128, exp_run: 64};

      reset = 1'b1;
      input_en = 1'b0;
      input_real = '0;
      input_imag = '0;
      fork
         monitor();
      join_none
      tick();
      tick();
      reset = 1'b0;
      check("reset_output_en", output_en, 0);
      check("reset_output_real", output_real, 0);
      check("reset_output_imag", output_imag, 0);

      // Latency: nothing at edge t, address 0 after edge t+1, last word after t+64.
      c0 = out_count;
      send_samples(0, 64, 0);
      check("lat_en_at_t", output_en, 0);
      tick();
      check("lat_en_at_t1", output_en, 1);
      check("lat_first_real", output_real, src_index(0));
      for (int i = 0; i < 63; i++) tick();
      check("lat_en_at_t64", output_en, 1);
      check("lat_last_real", output_real, src_index(63));
      tick();
      check("lat_en_at_t65", output_en, 0);
      drain();
      check("lat_count", out_count - c0, 64);

      for (int s = 0; s < 4; s++) begin
         c0 = out_count;
         r0 = runs.size();
         for (int f = 0; f < scen[s].frames; f++) begin
            send_samples(scen[s].base + f * 100, 64, scen[s].gap);
         end
         drain();
         mx = 0;
         for (int i = r0; i < runs.size(); i++) if (runs[i] > mx) mx = runs[i];
         check("scen_count", out_count - c0, scen[s].exp_count);
         check("scen_longest_run", mx, scen[s].exp_run);
      end

      // Reset after 20 samples: the partial frame must never appear.
      c0 = out_count;
      send_samples(7000, 20, 0);
      do_reset();
      send_samples(8000, 64, 0);
      drain();
      check("midframe_count", out_count - c0, 64);

      // Reset at burst output 10 aborts the burst with zeroed outputs.
      c0 = out_count;
      send_samples(9000, 64, 0);
      budget = 0;
      while (out_count - c0 < 10 && budget < 200) begin
         tick();
         budget++;
      end
      check("midburst_wait_timeout", budget >= 200, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      check("midburst_en", output_en, 0);
      check("midburst_real", output_real, 0);
      check("midburst_imag", output_imag, 0);
      tick();
      check("midburst_en_after", output_en, 0);
      drain();
      c0 = out_count;
      send_samples(11000, 64, 0);
      drain();
      check("after_midburst_count", out_count - c0, 64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
